// File: rtl/irq_seq.sv
// irq_seq: edge-latched interrupt sequencer. Waits for a safe EX slot, then
// flushes the pipe, saves EPC, clears IE and vectors to the winning handler.
`ifndef IM_ADDR_NBIT
`define IM_ADDR_NBIT 16
`endif

module irq_seq #(
    parameter int unsigned NIRQ       = 4,
    parameter int unsigned VEC_BASE   = 'h100,
    parameter int unsigned VEC_STRIDE = 'h10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NIRQ-1:0]          irq_in,
    input  logic [NIRQ-1:0]          irq_mask,
    input  logic                     ie,
    input  logic [`IM_ADDR_NBIT-1:0] ex_pc,
    input  logic                     ex_bubble,
    input  logic                     ex_eret,
    input  logic                     ex_halt,
    input  logic                     pic_stall,
    input  logic                     pic_redirect,
    output logic                     irq_flush,
    output logic [`IM_ADDR_NBIT-1:0] irq_vec,
    output logic                     epc_we,
    output logic                     ie_we,
    output logic [`IM_ADDR_NBIT-1:0] epc_val,
    output logic                     ie_val,
    output logic [NIRQ-1:0]          irq_ack,
    output logic [NIRQ-1:0]          pending,
    output logic                     in_handler,
    output logic [15:0]              irq_cnt
);

    localparam int unsigned AW = `IM_ADDR_NBIT;
    localparam int unsigned IW = (NIRQ > 1) ? $clog2(NIRQ) : 1;
    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_TAKE = 2'd2,
        S_BUSY = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [NIRQ-1:0] r_irq_d;
    logic            r_arm;
    logic [NIRQ-1:0] r_pending;
    logic [IW-1:0]   r_idx;
    logic [CW-1:0]   r_cnt;

    logic            r_flush;
    logic [AW-1:0]   r_vec;
    logic            r_epc_we;
    logic [AW-1:0]   r_epc_val;
    logic            r_ie_we;
    logic            r_ie_val;
    logic [NIRQ-1:0] r_ack;
    logic            r_in_handler;

    logic            w_flush_nxt;
    logic [AW-1:0]   w_vec_nxt;
    logic            w_epc_we_nxt;
    logic [AW-1:0]   w_epc_val_nxt;
    logic            w_ie_we_nxt;
    logic            w_ie_val_nxt;
    logic [NIRQ-1:0] w_ack_nxt;
    logic            w_in_handler_nxt;
    logic            w_take;

    logic [NIRQ-1:0] w_rise;
    logic [NIRQ-1:0] w_elig;
    logic [NIRQ-1:0] w_clr;
    logic [NIRQ-1:0] w_win_ack;
    logic [IW-1:0]   w_win_idx;
    logic [AW-1:0]   w_win_vec;
    logic            w_any;
    logic            w_safe;

    // r_arm masks the first post-reset cycle so lines held high through reset do not pend
    assign w_rise = irq_in & ~r_irq_d & {NIRQ{r_arm}};
    assign w_elig = r_pending & irq_mask;
    assign w_any  = |w_elig;
    assign w_safe = !ex_bubble && !ex_eret && !ex_halt && !pic_stall && !pic_redirect;

    // Lowest eligible index wins
    always_comb begin
        w_win_idx = '0;
        w_win_ack = '0;
        for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win_idx    = IW'(i);
                w_win_ack    = '0;
                w_win_ack[i] = 1'b1;
            end
        end
    end

    assign w_win_vec = AW'(VEC_BASE + 32'(w_win_idx) * VEC_STRIDE);

    // Pending bit of the acknowledged line drops at the end of the TAKE cycle
    always_comb begin
        w_clr = '0;
        if (r_state == S_TAKE) begin
            w_clr[r_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_flush_nxt      = 1'b0;
        w_vec_nxt        = '0;
        w_epc_we_nxt     = 1'b0;
        w_epc_val_nxt    = '0;
        w_ie_we_nxt      = 1'b0;
        w_ie_val_nxt     = 1'b0;
        w_ack_nxt        = '0;
        w_in_handler_nxt = 1'b0;
        w_take           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ie && w_any) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!ie || !w_any) begin
                    w_state_nxt = S_IDLE;
                end else if (w_safe) begin
                    w_state_nxt   = S_TAKE;
                    w_take        = 1'b1;
                    w_flush_nxt   = 1'b1;
                    w_vec_nxt     = w_win_vec;
                    w_epc_we_nxt  = 1'b1;
                    w_epc_val_nxt = ex_pc;
                    w_ie_we_nxt   = 1'b1;
                    w_ie_val_nxt  = 1'b0;
                    w_ack_nxt     = w_win_ack;
                end
            end
            S_TAKE: begin
                w_state_nxt      = S_BUSY;
                w_in_handler_nxt = 1'b1;
            end
            S_BUSY: begin
                if (ex_eret && !pic_stall) begin
                    w_state_nxt  = S_IDLE;
                    w_ie_we_nxt  = 1'b1;
                    w_ie_val_nxt = 1'b1;
                end else begin
                    w_in_handler_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Edge history, pending latch, frozen index and take counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_irq_d   <= '0;
            r_arm     <= 1'b0;
            r_pending <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
        end else begin
            r_irq_d   <= irq_in;
            r_arm     <= 1'b1;
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (w_take) begin
                r_idx <= w_win_idx;
                if (r_cnt != {CW{1'b1}}) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flush      <= 1'b0;
            r_vec        <= '0;
            r_epc_we     <= 1'b0;
            r_epc_val    <= '0;
            r_ie_we      <= 1'b0;
            r_ie_val     <= 1'b0;
            r_ack        <= '0;
            r_in_handler <= 1'b0;
        end else begin
            r_flush      <= w_flush_nxt;
            r_vec        <= w_vec_nxt;
            r_epc_we     <= w_epc_we_nxt;
            r_epc_val    <= w_epc_val_nxt;
            r_ie_we      <= w_ie_we_nxt;
            r_ie_val     <= w_ie_val_nxt;
            r_ack        <= w_ack_nxt;
            r_in_handler <= w_in_handler_nxt;
        end
    end

    assign irq_flush  = r_flush;
    assign irq_vec    = r_vec;
    assign epc_we     = r_epc_we;
    assign epc_val    = r_epc_val;
    assign ie_we      = r_ie_we;
    assign ie_val     = r_ie_val;
    assign irq_ack    = r_ack;
    assign pending    = r_pending;
    assign in_handler = r_in_handler;
    assign irq_cnt    = r_cnt;

endmodule
